lh_aes_hash: RTL and testbench
==============================

# lh_aes_hash

Parametrised, handshaked successor to the light-hash core. It absorbs a stream of plaintext bytes into an N_BYTES-wide state using the AES S-box, running ROUNDS rounds per byte under an explicit FSM, and emits the packed digest on the message's last byte. It sits between the byte-stream source (testbench or UART front end) and any digest consumer.

## Interface
- N_BYTES, 8: digest state width in bytes; must be ≥ 3.
- ROUNDS, 32: rounds applied per absorbed byte; must be ≥ 1.
- IV, '0 (8*N_BYTES bits): initial state. H[0] is taken from bits [8*N_BYTES-1 -: 8].
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ptxt_char  in  8  plaintext byte.
- ptxt_valid  in  1  byte present.
- ptxt_last  in  1  byte is the final byte of the message; sampled with ptxt_valid.
- ptxt_ready  out  1  core can accept a byte.
- digest  out  8*N_BYTES  packed digest, H[0] in the MSBs.
- digest_valid  out  1  digest holds a finished message.
- err_invalid_ptxt_char  out  1  one-cycle pulse for a rejected byte.

## Operation
- State H[0..N_BYTES-1] (8 bits each), round counter rcnt of width $clog2(ROUNDS+1), latched byte c, and latched last flag.
- FSM states:
  - IDLE: ptxt_ready=1. On valid&&ready, latch c and last, set rcnt=0, go to ABSORB.
  - ABSORB: ptxt_ready=0. Each cycle applies one round and increments rcnt. When rcnt==ROUNDS-1, go to IDLE. If last is set, also finalize.
- One round, computed from the old H for all j in parallel: t = H[(j+2)%N_BYTES] ^ c; t = rotl8(t, j%8); H'[j] = SBOX[t].
- Finalize: digest <= packed H' and digest_valid <= 1, in the same cycle that H <= IV.
- digest and digest_valid hold until the next accepted byte, which clears digest_valid. digest keeps its old value.
- Valid characters are 0x30–0x39, 0x41–0x5A and 0x61–0x7A. Character checking is configurable; see Configuration.
- Reset: H=IV, FSM=IDLE, ptxt_ready=1, digest=0, digest_valid=0, err_invalid_ptxt_char=0.
- Reset asserted mid-ABSORB aborts the message. No digest is produced.

## Timing
- A byte accepted at edge k has its rounds at edges k+1..k+ROUNDS. ptxt_ready is 0 from after edge k until edge k+ROUNDS, then returns to 1.
- Last byte: digest_valid rises at edge k+ROUNDS.
- Sustained throughput is one byte per ROUNDS+1 cycles.
- ptxt_valid while ptxt_ready=0 is ignored. The source must hold the byte.
- err_invalid_ptxt_char is registered: it is high for exactly the cycle after the rejecting edge.

## Configuration
- LH_CHAR_CHECK_EN defined:
  - An accepted byte outside the valid set is not absorbed. The FSM stays in IDLE and err_invalid_ptxt_char pulses.
  - If ptxt_last is set on a rejected byte, finalize happens immediately: digest <= H, digest_valid at the next edge, H <= IV.
- LH_CHAR_CHECK_EN undefined:
  - Every byte is absorbed.
  - err_invalid_ptxt_char is tied to 0.

## Structure
- Package lh_pkg holds:
  - the sbox function (256-entry LUT);
  - the state enum {IDLE, ABSORB};
  - the valid-character range constants;
  - the rotl8 function.
- Sub-module lh_round is purely combinational. Parameter N_BYTES; ports H_in, c, H_out. The core instantiates it once and registers its output.

## Test plan
- Reset, then check outputs: ptxt_ready=1, digest_valid=0, digest=0.
- N_BYTES=8, ROUNDS=1, IV=0: send '0' (0x30) with last -> one cycle later digest_valid=1, digest[63:48]=0x04D0 (SBOX[0x30], SBOX[0x60]).
- Default parameters: send "abc" with last on 'c' -> ptxt_ready low for exactly 32 cycles per byte. digest_valid rises 32 cycles after 'c' is accepted, and the digest matches the lh_pkg-based reference model.
- LH_CHAR_CHECK_EN: send 'a', then '#' (0x23), then 'b' with last -> a single err pulse after '#'. The digest equals that of "ab".
- Assert rst_n low mid-ABSORB, then send "ab" with last -> the digest equals a fresh "ab" digest.
- Send two messages back-to-back -> digest_valid clears on the first byte of message 2, and the second digest is independent of message 1.

Source files
------------

// File: rtl/lh_pkg.sv
// rtl/lh_pkg.sv - shared types, AES S-box, rotate helper and character ranges for lh_aes_hash
package lh_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ABSORB = 1'b1
  } lh_state_e;

  localparam logic [7:0] CH_DIGIT_LO = 8'h30;
  localparam logic [7:0] CH_DIGIT_HI = 8'h39;
  localparam logic [7:0] CH_UPPER_LO = 8'h41;
  localparam logic [7:0] CH_UPPER_HI = 8'h5A;
  localparam logic [7:0] CH_LOWER_LO = 8'h61;
  localparam logic [7:0] CH_LOWER_HI = 8'h7A;

  localparam logic [0:255][7:0] SBOX_TBL = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[x];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input logic [2:0] amt);
    logic [15:0] d;
    d = {x, x} << amt;
    return d[15:8];
  endfunction

  function automatic logic is_valid_char(input logic [7:0] b);
    return ((b >= CH_DIGIT_LO) && (b <= CH_DIGIT_HI)) ||
           ((b >= CH_UPPER_LO) && (b <= CH_UPPER_HI)) ||
           ((b >= CH_LOWER_LO) && (b <= CH_LOWER_HI));
  endfunction

endpackage

// File: rtl/lh_round.sv
// rtl/lh_round.sv - one combinational absorb round over the packed state (H[0] in the MSBs)
module lh_round
  import lh_pkg::*;
#(
  parameter int N_BYTES = 8
) (
  input  logic [8*N_BYTES-1:0] H_in,
  input  logic [7:0]           c,
  output logic [8*N_BYTES-1:0] H_out
);

  for (genvar j = 0; j < N_BYTES; j++) begin : g_byte
    localparam int SRC = (j + 2) % N_BYTES;
    logic [7:0] t;
    assign t = H_in[8*(N_BYTES-SRC)-1 -: 8] ^ c;
    assign H_out[8*(N_BYTES-j)-1 -: 8] = sbox(rotl8(t, 3'(j % 8)));
  end

endmodule

// File: rtl/lh_aes_hash.sv
// rtl/lh_aes_hash.sv - handshaked S-box byte hash core; LH_CHAR_CHECK_EN enables plaintext character filtering
module lh_aes_hash
  import lh_pkg::*;
#(
  parameter int                   N_BYTES = 8,
  parameter int                   ROUNDS  = 32,
  parameter logic [8*N_BYTES-1:0] IV      = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             ptxt_char,
  input  logic                   ptxt_valid,
  input  logic                   ptxt_last,
  output logic                   ptxt_ready,
  output logic [8*N_BYTES-1:0]   digest,
  output logic                   digest_valid,
  output logic                   err_invalid_ptxt_char
);

  localparam int CW = $clog2(ROUNDS + 1);
  localparam logic [CW-1:0] RCNT_LAST = CW'(ROUNDS - 1);

  lh_state_e              state;
  logic [8*N_BYTES-1:0]   h;
  logic [8*N_BYTES-1:0]   h_next;
  logic [CW-1:0]          rcnt;
  logic [7:0]             c_q;
  logic                   last_q;
`ifdef LH_CHAR_CHECK_EN
  logic                   err_q;
`endif

  lh_round #(.N_BYTES(N_BYTES)) u_round (
    .H_in  (h),
    .c     (c_q),
    .H_out (h_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      h            <= IV;
      rcnt         <= '0;
      c_q          <= '0;
      last_q       <= 1'b0;
      ptxt_ready   <= 1'b1;
      digest       <= '0;
      digest_valid <= 1'b0;
`ifdef LH_CHAR_CHECK_EN
      err_q        <= 1'b0;
`endif
    end else begin
`ifdef LH_CHAR_CHECK_EN
      err_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (ptxt_valid && ptxt_ready) begin
            digest_valid <= 1'b0;
`ifdef LH_CHAR_CHECK_EN
            // Rejected bytes leave H untouched but can still close the message
            if (!is_valid_char(ptxt_char)) begin
              err_q <= 1'b1;
              if (ptxt_last) begin
                digest       <= h;
                digest_valid <= 1'b1;
                h            <= IV;
              end
            end else
`endif
            begin
              c_q        <= ptxt_char;
              last_q     <= ptxt_last;
              rcnt       <= '0;
              ptxt_ready <= 1'b0;
              state      <= ABSORB;
            end
          end
        end
        ABSORB: begin
          h    <= h_next;
          rcnt <= rcnt + CW'(1);
          if (rcnt == RCNT_LAST) begin
            state      <= IDLE;
            ptxt_ready <= 1'b1;
            if (last_q) begin
              digest       <= h_next;
              digest_valid <= 1'b1;
              h            <= IV;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LH_CHAR_CHECK_EN
  assign err_invalid_ptxt_char = err_q;
`else
  assign err_invalid_ptxt_char = 1'b0;
`endif

endmodule

// File: tb/tb_lh_aes_hash.sv
// tb/tb_lh_aes_hash.sv - self-checking bench for lh_aes_hash (default and ROUNDS=1 instances)
module tb_lh_aes_hash;
  import lh_pkg::*;

  localparam int RD = 32;
`ifdef LH_CHAR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic [31:0] msg;
    int          len;
    logic [63:0] exp_digest;
    int          exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  ptxt_char = '0;
  logic        ptxt_valid = 1'b0, ptxt_last = 1'b0;
  logic        ptxt_ready, digest_valid, err_invalid_ptxt_char;
  logic [63:0] digest;
  logic [7:0]  ptxt_char1 = '0;
  logic        ptxt_valid1 = 1'b0, ptxt_last1 = 1'b0;
  logic        ptxt_ready1, digest_valid1, err1;
  logic [63:0] digest1;

  always #5 clk = ~clk;

  lh_aes_hash u_dut (
    .clk(clk), .rst_n(rst_n), .ptxt_char(ptxt_char), .ptxt_valid(ptxt_valid),
    .ptxt_last(ptxt_last), .ptxt_ready(ptxt_ready), .digest(digest),
    .digest_valid(digest_valid), .err_invalid_ptxt_char(err_invalid_ptxt_char)
  );

  lh_aes_hash #(.N_BYTES(8), .ROUNDS(1), .IV(64'h0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ptxt_char(ptxt_char1), .ptxt_valid(ptxt_valid1),
    .ptxt_last(ptxt_last1), .ptxt_ready(ptxt_ready1), .digest(digest1),
    .digest_valid(digest_valid1), .err_invalid_ptxt_char(err1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int err_cycles = 0;
  logic [63:0] sb_q[$];
  logic dv_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rot(input logic [7:0] x, input int n);
    logic [7:0] r;
    if (n == 0) r = x;
    else r = (x << n) | (x >> (8 - n));
    return r;
  endfunction

  function automatic bit char_ok(input logic [7:0] b);
    return (b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A);
  endfunction

  function automatic logic [63:0] step(input logic [63:0] h, input logic [7:0] c);
    logic [63:0] r;
    logic [7:0]  t;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      t = h[63-8*((j+2)%8) -: 8] ^ c;
      r[63-8*j -: 8] = sbox(rot(t, j));
    end
    return r;
  endfunction

  function automatic logic [63:0] model(input logic [31:0] msg, input int len, input int rounds);
    logic [63:0] h, d;
    logic [7:0]  b;
    h = '0;
    d = '0;
    for (int k = 0; k < len; k++) begin
      b = msg[31-8*k -: 8];
      if (CHK && !char_ok(b)) begin
        if (k == len - 1) d = h;
        continue;
      end
      for (int r = 0; r < rounds; r++) h = step(h, b);
      if (k == len - 1) d = h;
    end
    return d;
  endfunction

  // Scoreboard: every rising digest_valid consumes one expected digest
  always @(negedge clk) begin
    if (digest_valid === 1'b1 && dv_prev === 1'b0) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_digest: got %h expected none", digest);
      end else begin
        check("digest", digest, sb_q.pop_front());
      end
    end
    dv_prev = digest_valid;
    if (err_invalid_ptxt_char === 1'b1) err_cycles++;
  end

  task automatic send_byte(input logic [7:0] b, input bit last);
    bit rej;
    int t;
    int cnt;
    rej = CHK && !char_ok(b);
    t = 0;
    while (ptxt_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("ready_timeout", {63'b0, ptxt_ready}, 64'd1);
    ptxt_char  = b;
    ptxt_valid = 1'b1;
    ptxt_last  = last;
    @(posedge clk);
    #1;
    ptxt_valid = 1'b0;
    ptxt_last  = 1'b0;
    @(negedge clk);
    check("err_pulse", {63'b0, err_invalid_ptxt_char}, {63'b0, rej});
    check("dv_after_accept", {63'b0, digest_valid}, {63'b0, rej && last});
    cnt = 0;
    while (ptxt_ready === 1'b0 && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    check("ready_low_cycles", 64'(cnt), rej ? 64'd0 : 64'(RD));
    if (last && !rej) check("dv_on_done", {63'b0, digest_valid}, 64'd1);
  endtask

  initial begin
    vec_t        tbl[6];
    logic [63:0] got[6];
    logic [7:0]  b;
    int          t;

    tbl[0] = '{msg: {8'h61, 8'h62, 8'h63, 8'h00}, len: 3, exp_digest: '0, exp_err: 0};
    tbl[1] = '{msg: {8'h61, 8'h62, 8'h00, 8'h00}, len: 2, exp_digest: '0, exp_err: 0};
    tbl[2] = '{msg: {8'h61, 8'h23, 8'h62, 8'h00}, len: 3, exp_digest: '0, exp_err: 0};
    tbl[3] = '{msg: {8'h5A, 8'h39, 8'h00, 8'h00}, len: 2, exp_digest: '0, exp_err: 0};
    tbl[4] = '{msg: {8'h61, 8'h21, 8'h00, 8'h00}, len: 2, exp_digest: '0, exp_err: 0};
    tbl[5] = '{msg: {8'h61, 8'h62, 8'h00, 8'h00}, len: 2, exp_digest: '0, exp_err: 0};
    for (int i = 0; i < 6; i++) begin
      tbl[i].exp_digest = model(tbl[i].msg, tbl[i].len, RD);
      for (int k = 0; k < tbl[i].len; k++) begin
        b = tbl[i].msg[31-8*k -: 8];
        if (CHK && !char_ok(b)) tbl[i].exp_err++;
      end
    end

    repeat (2) @(negedge clk);
    check("rst_ready", {63'b0, ptxt_ready}, 64'd1);
    check("rst_dv", {63'b0, digest_valid}, 64'd0);
    check("rst_digest", digest, 64'd0);
    check("rst_err", {63'b0, err_invalid_ptxt_char}, 64'd0);
    check("rst_ready1", {63'b0, ptxt_ready1}, 64'd1);
    check("rst_digest1", digest1, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    ptxt_char1  = 8'h30;
    ptxt_valid1 = 1'b1;
    ptxt_last1  = 1'b1;
    @(posedge clk);
    #1;
    ptxt_valid1 = 1'b0;
    ptxt_last1  = 1'b0;
    @(negedge clk);
    check("r1_dv_early", {63'b0, digest_valid1}, 64'd0);
    check("r1_ready_low", {63'b0, ptxt_ready1}, 64'd0);
    @(negedge clk);
    check("r1_dv", {63'b0, digest_valid1}, 64'd1);
    check("r1_top16", {48'b0, digest1[63:48]}, 64'h04D0);
    check("r1_digest", digest1, model({8'h30, 24'h0}, 1, 1));
    check("r1_ready_back", {63'b0, ptxt_ready1}, 64'd1);

    for (int i = 0; i < 6; i++) begin
      err_cycles = 0;
      sb_q.push_back(tbl[i].exp_digest);
      for (int k = 0; k < tbl[i].len; k++)
        send_byte(tbl[i].msg[31-8*k -: 8], k == tbl[i].len - 1);
      repeat (2) @(negedge clk);
      check("err_cycles", 64'(err_cycles), 64'(tbl[i].exp_err));
      got[i] = digest;
    end
    check("independent_msg", got[5], got[1]);
    if (CHK) check("filtered_eq_ab", got[2], got[1]);

    t = 0;
    while (ptxt_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    ptxt_char  = 8'h78;
    ptxt_valid = 1'b1;
    ptxt_last  = 1'b0;
    @(posedge clk);
    #1;
    ptxt_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_ready", {63'b0, ptxt_ready}, 64'd1);
    check("midrst_dv", {63'b0, digest_valid}, 64'd0);
    check("midrst_digest", digest, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    sb_q.push_back(model({8'h61, 8'h62, 16'h0}, 2, RD));
    send_byte(8'h61, 1'b0);
    send_byte(8'h62, 1'b1);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
